control_unit: RTL
=================

# control_unit

Sequencing controller for the 16-bit bus datapath. It captures a 9-bit instruction from `din`, then steps through up to four timesteps (T0–T3). In each step it drives the one-hot bus-source selects consumed by the bus multiplexer (`r_out[7:0]`, `din_out`, `g_out`) and the register load enables on the receiving end of `buswires` (`r_in[7:0]`, `a_in`, `g_in`, `ir_in`). It also supplies the ALU operation code and a `done` pulse.

## Interface
Parameters:
- none (widths fixed: 16-bit bus, 9-bit IR, 8 registers)

Ports:
- `clock`  input  1  system clock, all state updates on rising edge
- `resetn`  input  1  synchronous, active-low reset
- `run`  input  1  start request, sampled only in T0
- `din`  input  16  external data word; bits [8:0] give the instruction in T0
- `r_out`  output  8  one-hot select: Rn drives bus
- `din_out`  output  1  select: DIN drives bus
- `g_out`  output  1  select: G drives bus
- `r_in`  output  8  one-hot load enable: Rn <= bus
- `a_in`  output  1  load enable: A <= bus
- `g_in`  output  1  load enable: G <= ALU result
- `ir_in`  output  1  IR capture strobe (observability)
- `alu_op`  output  3  ALU function
- `done`  output  1  last cycle of instruction
- `ir`  output  9  current instruction register

## Operation
IR format:
- `ir[8:6]` is the opcode III.
- `ir[5:3]` is X, the destination and first operand.
- `ir[2:0]` is Y, the second operand.

Opcodes:
- 000 mv
- 001 mvi
- 010 add
- 011 sub
- 100 and
- 101 slt
- 110 sll
- 111 srl

State:
- 2-bit step counter T0..T3 and the 9-bit `ir` register; both registered.
- All other outputs are combinational decodes of step, `ir` and `run`.

Per-step actions. Signals not listed are 0.
- T0:
  - If `run`=1: `ir_in`=1, `ir` <= `din[8:0]`, step -> T1.
  - Else: hold T0, all outputs 0.
- T1, mv: `r_out[Y]`=1, `r_in[X]`=1, `done`=1; step -> T0.
- T1, mvi: `din_out`=1, `r_in[X]`=1, `done`=1; step -> T0. The immediate word is on `din` during this cycle.
- T1, ALU ops (010–111): `r_out[X]`=1, `a_in`=1; step -> T2.
- T2, ALU ops: `r_out[Y]`=1, `g_in`=1, `alu_op`=`ir[8:6]`; step -> T3.
- T3, ALU ops: `g_out`=1, `r_in[X]`=1, `done`=1; step -> T0.
- `alu_op` = 000 in every step other than T2.

Invariants:
- At most one of {`r_out[*]`, `din_out`, `g_out`} is 1 in any cycle.
- At most one `r_in` bit is 1 in any cycle.
- `ir` changes only on a T0 edge with `run`=1, or on reset.
- X=Y is legal, e.g. `mv R3,R3` or `add R2,R2`.

Boundary conditions:
- `run` is ignored outside T0. Deasserting it mid-instruction does not abort.
- `run` held high: the next fetch occurs in the cycle immediately after `done`.
- `din` outside T0 and mvi-T1 has no effect.

## Timing
- Latency from fetch edge:
  - mv / mvi: 2 cycles (T0, T1).
  - ALU ops: 4 cycles (T0–T3).
- `done` is high for exactly 1 cycle, in the final step.
- Reset: a rising edge with `resetn`=0 sets step <= T0 and `ir` <= 0, regardless of current step.
- While `resetn`=0, all outputs except `ir` are forced to 0 in the same cycle. No `r_in` or `g_in` fires during reset.
- Reset mid-instruction aborts it with no further register writes. The first cycle after release is T0.

## Test plan
- Reset, then `resetn`=1 with `run`=0: all selects/enables 0, `ir`=0, `done`=0, step stays T0 for 10 cycles.
- mvi R2,#5:
  - T0: `din`=9'b001_010_000, `run`=1 gives `ir_in`=1.
  - T1: `din`=16'h0005 gives `din_out`=1, `r_in`=8'b0000_0100, `done`=1.
  - Then back to T0.
- mv R0,R2 (`din`=9'b000_000_010): T1 gives `r_out`=8'b0000_0100, `r_in`=8'b0000_0001, `done`=1. Completes in 2 cycles.
- add R1,R3 (9'b010_001_011):
  - T1: `r_out`=8'h02, `a_in`=1.
  - T2: `r_out`=8'h08, `g_in`=1, `alu_op`=010.
  - T3: `g_out`=1, `r_in`=8'h02, `done`=1.
- `run` held high across sub R4,R5 followed by mv R6,R4: `done` at cycles 4 and 6, `ir_in` at cycles 1 and 5, no idle cycle between instructions.
- `resetn`=0 asserted in T2 of slt: `g_in`=0 in that cycle, step=T0 and `ir`=0 next cycle, no `r_in` pulse ever seen for that instruction. Every cycle of every test also checks one-hot bus-source exclusivity.

Source files
------------

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit
//  Description : Instruction sequencer for the 16-bit bus datapath. Captures
//                a 9-bit instruction, then walks T0..T3 driving one-hot bus
//                source selects, register load enables, ALU op and done.
//  Revision    : 1.0  - initial release
// ============================================================================
module control_unit (
    input  logic        clock,
    input  logic        resetn,
    input  logic        run,
    input  logic [15:0] din,
    output logic [7:0]  r_out,
    output logic        din_out,
    output logic        g_out,
    output logic [7:0]  r_in,
    output logic        a_in,
    output logic        g_in,
    output logic        ir_in,
    output logic [2:0]  alu_op,
    output logic        done,
    output logic [8:0]  ir
);

    // ------------------------------------------------------------------------
    // Opcode encodings (ir[8:6])
    // ------------------------------------------------------------------------
    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;

    // Step counter; four timesteps fit exactly in two bits.
    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    step_t      step_q, step_d;
    logic [8:0] ir_q, ir_d;

    // Instruction fields of the currently held instruction.
    logic [2:0] opcode;
    logic [2:0] reg_x;
    logic [2:0] reg_y;

    assign opcode = ir_q[8:6];
    assign reg_x  = ir_q[5:3];
    assign reg_y  = ir_q[2:0];
    assign ir     = ir_q;

    // Only din[8:0] carries an instruction; the upper bits reach the bus
    // through the datapath mux, never through this block.
    logic unused_din_hi;
    assign unused_din_hi = ^din[15:9];

    // Turn a 3-bit register index into its one-hot select/enable.
    function automatic logic [7:0] reg_onehot(input logic [2:0] idx);
        logic [7:0] vec;
        vec      = 8'b0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // State register: step counter and instruction register, sync active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            step_q <= T0;
            ir_q   <= 9'b0;
        end else begin
            step_q <= step_d;
            ir_q   <= ir_d;
        end
    end

    // Next-step and output decode; everything except ir is forced low in reset
    // so no load enable can fire during an aborting reset cycle.
    always_comb begin
        step_d  = step_q;
        ir_d    = ir_q;
        r_out   = 8'b0;
        din_out = 1'b0;
        g_out   = 1'b0;
        r_in    = 8'b0;
        a_in    = 1'b0;
        g_in    = 1'b0;
        ir_in   = 1'b0;
        alu_op  = 3'b000;
        done    = 1'b0;

        if (resetn) begin
            case (step_q)
                // Fetch: run is only honoured here.
                T0: begin
                    if (run) begin
                        ir_in  = 1'b1;
                        ir_d   = din[8:0];
                        step_d = T1;
                    end
                end

                // Moves finish here; ALU ops latch operand X into A.
                T1: begin
                    if (opcode == OP_MV) begin
                        r_out  = reg_onehot(reg_y);
                        r_in   = reg_onehot(reg_x);
                        done   = 1'b1;
                        step_d = T0;
                    end else if (opcode == OP_MVI) begin
                        din_out = 1'b1;
                        r_in    = reg_onehot(reg_x);
                        done    = 1'b1;
                        step_d  = T0;
                    end else begin
                        r_out  = reg_onehot(reg_x);
                        a_in   = 1'b1;
                        step_d = T2;
                    end
                end

                // ALU ops: operand Y on the bus, result captured into G.
                T2: begin
                    r_out  = reg_onehot(reg_y);
                    g_in   = 1'b1;
                    alu_op = opcode;
                    step_d = T3;
                end

                // ALU ops: write G back into X.
                T3: begin
                    g_out  = 1'b1;
                    r_in   = reg_onehot(reg_x);
                    done   = 1'b1;
                    step_d = T0;
                end

                default: step_d = T0;
            endcase
        end
    end

endmodule
`default_nettype wire
